// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, register count, index width and the hardwired zero register.
package pipeline_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned RETIRE_W = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/writeback_regfile_if.sv
// Writeback / decode-read bus between the MEM/WB stage, decode and the forwarding unit.
interface writeback_regfile_if #(
  parameter int unsigned DATA_W = pipeline_pkg::DATA_W
);

  logic [DATA_W-1:0]               saidaALUwb;
  logic [DATA_W-1:0]               saidaMEM;
  logic [pipeline_pkg::ADDR_W-1:0] saidaDestinoData;
  logic                            registradorEscrita;
  logic                            registradorMEM;
  logic [pipeline_pkg::ADDR_W-1:0] rs_addr;
  logic [pipeline_pkg::ADDR_W-1:0] rt_addr;

  logic [DATA_W-1:0]                 rs_data;
  logic [DATA_W-1:0]                 rt_data;
  logic [DATA_W-1:0]                 wb_data;
  logic [pipeline_pkg::ADDR_W-1:0]   wb_dest;
  logic                              wb_en;
  logic [pipeline_pkg::RETIRE_W-1:0] retire_count;

  modport master (
    output saidaALUwb, saidaMEM, saidaDestinoData, registradorEscrita, registradorMEM,
    output rs_addr, rt_addr,
    input  rs_data, rt_data, wb_data, wb_dest, wb_en, retire_count
  );

  modport slave (
    input  saidaALUwb, saidaMEM, saidaDestinoData, registradorEscrita, registradorMEM,
    input  rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_dest, wb_en, retire_count
  );

endinterface

// File: rtl/regfile_core.sv
// Register storage: synchronous clear, one write port, two raw combinational read ports.
module regfile_core
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W   = pipeline_pkg::DATA_W,
  parameter int unsigned NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [ADDR_W-1:0]    raddr_a_i,
  input  logic [ADDR_W-1:0]    raddr_b_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  output logic [DATA_W-1:0]    rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic wr_ok_c;
  assign wr_ok_c = we_i && (waddr_i != REG_ZERO) && (32'(waddr_i) < NUM_REGS);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) mem_q[i] <= '0;
    end else if (wr_ok_c) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Index 0 and indices beyond the array read as zero.
  always_comb begin
    rdata_a_o = '0;
    rdata_b_o = '0;
    if ((raddr_a_i != REG_ZERO) && (32'(raddr_a_i) < NUM_REGS)) rdata_a_o = mem_q[raddr_a_i];
    if ((raddr_b_i != REG_ZERO) && (32'(raddr_b_i) < NUM_REGS)) rdata_b_o = mem_q[raddr_b_i];
  end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: result mux, write-first read bypass, register file and committed-write counter.
module writeback_regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W   = pipeline_pkg::DATA_W,
  parameter int unsigned NUM_REGS = pipeline_pkg::NUM_REGS
) (
  input  logic               Clock,
  input  logic               Resetn,
  writeback_regfile_if.slave bus
);

  logic [DATA_W-1:0]   wb_data_c;
  logic                wb_en_c;
  logic [DATA_W-1:0]   raw_rs_c;
  logic [DATA_W-1:0]   raw_rt_c;
  logic [RETIRE_W-1:0] retire_d;
  logic [RETIRE_W-1:0] retire_q;

  assign wb_data_c = bus.registradorMEM ? bus.saidaMEM : bus.saidaALUwb;
  assign wb_en_c   = bus.registradorEscrita && (bus.saidaDestinoData != REG_ZERO);

  regfile_core #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_core (
    .clk_i     (Clock),
    .rst_ni    (Resetn),
    .we_i      (wb_en_c),
    .waddr_i   (bus.saidaDestinoData),
    .wdata_i   (wb_data_c),
    .raddr_a_i (bus.rs_addr),
    .raddr_b_i (bus.rt_addr),
    .rdata_a_o (raw_rs_c),
    .rdata_b_o (raw_rt_c)
  );

  // Bypass is gated by wb_en so a stale or X mux select never reaches the read ports.
  always_comb begin
    bus.rs_data = raw_rs_c;
    bus.rt_data = raw_rt_c;
    if (wb_en_c && (bus.rs_addr == bus.saidaDestinoData)) bus.rs_data = wb_data_c;
    if (wb_en_c && (bus.rt_addr == bus.saidaDestinoData)) bus.rt_data = wb_data_c;
  end

  assign bus.wb_data      = wb_data_c;
  assign bus.wb_dest      = bus.saidaDestinoData;
  assign bus.wb_en        = wb_en_c;
  assign bus.retire_count = retire_q;

  always_comb begin
    retire_d = retire_q;
    if (wb_en_c) retire_d = retire_q + RETIRE_W'(1);
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) retire_q <= '0;
    else         retire_q <= retire_d;
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: mux, bypass, zero register, reset interaction and counter wrap.
module tb_writeback_regfile;

  logic Clock;
  logic Resetn;
  int   n_vec;
  int   n_err;

  writeback_regfile_if #(.DATA_W(32)) bus ();

  writeback_regfile #(.DATA_W(32), .NUM_REGS(32)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic drive_idle();
    bus.saidaALUwb         = '0;
    bus.saidaMEM           = '0;
    bus.saidaDestinoData   = '0;
    bus.registradorEscrita = 1'b0;
    bus.registradorMEM     = 1'b0;
  endtask

  task automatic drive_write(input logic [4:0] dest, input logic [31:0] alu,
                             input logic [31:0] mem, input logic sel);
    bus.saidaDestinoData   = dest;
    bus.saidaALUwb         = alu;
    bus.saidaMEM           = mem;
    bus.registradorMEM     = sel;
    bus.registradorEscrita = 1'b1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    drive_idle();
    bus.rs_addr = '0;
    bus.rt_addr = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs_addr = 5'(i);
      bus.rt_addr = 5'(31 - i);
      #1;
      n_vec++; if (bus.rs_data !== 32'h0) begin n_err++; $display("FAIL reset_rs[%0d]: got %h want %h", i, bus.rs_data, 32'h0); end
      n_vec++; if (bus.rt_data !== 32'h0) begin n_err++; $display("FAIL reset_rt[%0d]: got %h want %h", 31 - i, bus.rt_data, 32'h0); end
    end
    n_vec++; if (bus.retire_count !== 32'h0) begin n_err++; $display("FAIL reset_retire: got %h want %h", bus.retire_count, 32'h0); end
  endtask

  task automatic test_alu_write();
    @(negedge Clock);
    drive_write(5'd5, 32'h1234_5678, 32'hCAFE_0000, 1'b0);
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    #1;
    n_vec++; if (bus.wb_data !== 32'h1234_5678) begin n_err++; $display("FAIL alu_wb_data: got %h want %h", bus.wb_data, 32'h1234_5678); end
    n_vec++; if (bus.wb_en !== 1'b1) begin n_err++; $display("FAIL alu_wb_en: got %b want 1", bus.wb_en); end
    n_vec++; if (bus.wb_dest !== 5'd5) begin n_err++; $display("FAIL alu_wb_dest: got %0d want 5", bus.wb_dest); end
    @(negedge Clock);
    drive_idle();
    bus.rs_addr = 5'd5;
    #1;
    n_vec++; if (bus.rs_data !== 32'h1234_5678) begin n_err++; $display("FAIL alu_read_r5: got %h want %h", bus.rs_data, 32'h1234_5678); end
    n_vec++; if (bus.retire_count !== 32'd1) begin n_err++; $display("FAIL alu_retire: got %0d want 1", bus.retire_count); end
  endtask

  task automatic test_mem_bypass();
    @(negedge Clock);
    drive_write(5'd9, 32'h0000_0001, 32'hDEAD_BEEF, 1'b1);
    bus.rs_addr = 5'd9;
    bus.rt_addr = 5'd9;
    #1;
    n_vec++; if (bus.wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_wb_data: got %h want %h", bus.wb_data, 32'hDEAD_BEEF); end
    n_vec++; if (bus.rs_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_bypass_rs: got %h want %h", bus.rs_data, 32'hDEAD_BEEF); end
    n_vec++; if (bus.rt_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_bypass_rt: got %h want %h", bus.rt_data, 32'hDEAD_BEEF); end
    @(negedge Clock);
    drive_idle();
    #1;
    n_vec++; if (bus.rs_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mem_stored_r9: got %h want %h", bus.rs_data, 32'hDEAD_BEEF); end
    n_vec++; if (bus.retire_count !== 32'd2) begin n_err++; $display("FAIL mem_retire: got %0d want 2", bus.retire_count); end
  endtask

  task automatic test_reg_zero();
    @(negedge Clock);
    drive_write(5'd0, 32'hFFFF_FFFF, 32'h0, 1'b0);
    bus.rs_addr = 5'd0;
    bus.rt_addr = 5'd0;
    #1;
    n_vec++; if (bus.wb_en !== 1'b0) begin n_err++; $display("FAIL r0_wb_en: got %b want 0", bus.wb_en); end
    n_vec++; if (bus.rs_data !== 32'h0) begin n_err++; $display("FAIL r0_no_bypass: got %h want %h", bus.rs_data, 32'h0); end
    @(negedge Clock);
    drive_idle();
    #1;
    n_vec++; if (bus.rt_data !== 32'h0) begin n_err++; $display("FAIL r0_read: got %h want %h", bus.rt_data, 32'h0); end
    n_vec++; if (bus.retire_count !== 32'd2) begin n_err++; $display("FAIL r0_retire: got %0d want 2", bus.retire_count); end
  endtask

  task automatic test_independent_bypass();
    @(negedge Clock);
    drive_write(5'd5, 32'hA5A5_0001, 32'h0, 1'b0);
    bus.rs_addr = 5'd9;
    bus.rt_addr = 5'd5;
    #1;
    n_vec++; if (bus.rs_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL indep_rs: got %h want %h", bus.rs_data, 32'hDEAD_BEEF); end
    n_vec++; if (bus.rt_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL indep_rt: got %h want %h", bus.rt_data, 32'hA5A5_0001); end
  endtask

  task automatic test_back_to_back();
    @(negedge Clock);
    drive_write(5'd7, 32'h0000_0077, 32'h0, 1'b0);
    bus.rs_addr = 5'd5;
    bus.rt_addr = 5'd0;
    #1;
    n_vec++; if (bus.rs_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL b2b_r5: got %h want %h", bus.rs_data, 32'hA5A5_0001); end
    @(negedge Clock);
    drive_write(5'd7, 32'h0, 32'h0000_0088, 1'b1);
    bus.rs_addr = 5'd7;
    #1;
    n_vec++; if (bus.rs_data !== 32'h0000_0088) begin n_err++; $display("FAIL b2b_bypass_r7: got %h want %h", bus.rs_data, 32'h0000_0088); end
    @(negedge Clock);
    drive_idle();
    #1;
    n_vec++; if (bus.rs_data !== 32'h0000_0088) begin n_err++; $display("FAIL b2b_stored_r7: got %h want %h", bus.rs_data, 32'h0000_0088); end
    n_vec++; if (bus.retire_count !== 32'd5) begin n_err++; $display("FAIL b2b_retire: got %0d want 5", bus.retire_count); end
  endtask

  task automatic test_x_memsel();
    @(negedge Clock);
    bus.saidaDestinoData   = 5'd5;
    bus.saidaALUwb         = 32'h5555_5555;
    bus.registradorMEM     = 1'bx;
    bus.registradorEscrita = 1'b0;
    bus.rs_addr            = 5'd5;
    #1;
    n_vec++; if (bus.wb_en !== 1'b0) begin n_err++; $display("FAIL xsel_wb_en: got %b want 0", bus.wb_en); end
    n_vec++; if (bus.rs_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL xsel_rs_live: got %h want %h", bus.rs_data, 32'hA5A5_0001); end
    @(negedge Clock);
    drive_idle();
    #1;
    n_vec++; if (bus.rs_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL xsel_r5_kept: got %h want %h", bus.rs_data, 32'hA5A5_0001); end
    n_vec++; if (bus.retire_count !== 32'd5) begin n_err++; $display("FAIL xsel_retire: got %0d want 5", bus.retire_count); end
  endtask

  task automatic test_write_during_reset();
    @(negedge Clock);
    Resetn = 1'b0;
    drive_write(5'd3, 32'h0000_0033, 32'h0, 1'b0);
    bus.rs_addr = 5'd3;
    bus.rt_addr = 5'd5;
    #1;
    n_vec++; if (bus.rs_data !== 32'h0000_0033) begin n_err++; $display("FAIL rst_bypass_rs: got %h want %h", bus.rs_data, 32'h0000_0033); end
    n_vec++; if (bus.rt_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL rst_pre_edge_rt: got %h want %h", bus.rt_data, 32'hA5A5_0001); end
    @(negedge Clock);
    Resetn = 1'b1;
    drive_idle();
    #1;
    n_vec++; if (bus.rs_data !== 32'h0) begin n_err++; $display("FAIL rst_r3_dropped: got %h want %h", bus.rs_data, 32'h0); end
    n_vec++; if (bus.rt_data !== 32'h0) begin n_err++; $display("FAIL rst_r5_cleared: got %h want %h", bus.rt_data, 32'h0); end
    n_vec++; if (bus.retire_count !== 32'd0) begin n_err++; $display("FAIL rst_retire: got %0d want 0", bus.retire_count); end
    drive_write(5'd3, 32'h0000_3333, 32'h0, 1'b0);
    @(negedge Clock);
    drive_idle();
    #1;
    n_vec++; if (bus.rs_data !== 32'h0000_3333) begin n_err++; $display("FAIL post_rst_write: got %h want %h", bus.rs_data, 32'h0000_3333); end
    n_vec++; if (bus.retire_count !== 32'd1) begin n_err++; $display("FAIL post_rst_retire: got %0d want 1", bus.retire_count); end
  endtask

  task automatic test_retire_wrap();
    @(negedge Clock);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    n_vec++; if (bus.retire_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h want %h", bus.retire_count, 32'hFFFF_FFFF); end
    drive_write(5'd1, 32'h1111_2222, 32'h0, 1'b0);
    bus.rs_addr = 5'd0;
    @(negedge Clock);
    drive_idle();
    bus.rs_addr = 5'd1;
    #1;
    n_vec++; if (bus.retire_count !== 32'h0) begin n_err++; $display("FAIL wrap_retire: got %h want %h", bus.retire_count, 32'h0); end
    n_vec++; if (bus.rs_data !== 32'h1111_2222) begin n_err++; $display("FAIL wrap_r1: got %h want %h", bus.rs_data, 32'h1111_2222); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_alu_write();
    test_mem_bypass();
    test_reg_zero();
    test_independent_bypass();
    test_back_to_back();
    test_x_memsel();
    test_write_during_reset();
    test_retire_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
